// File: rtl/uart_fifo_transceiver.sv
// Full-duplex UART with per-direction FIFOs, optional parity and sticky RX error flags.
// RX words are held in a first-word fall-through FIFO that consumers pop.
module uart_fifo_transceiver #(
    parameter int CLKS_PER_BIT = 5209,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                 i_Clock,
    input  logic                 i_Rst_n,
    input  logic                 i_Tx_DV,
    input  logic [DATA_BITS-1:0] i_Tx_Byte,
    output logic                 o_Tx_Ready,
    output logic                 o_Tx_Serial,
    output logic                 o_Tx_Active,
    output logic                 o_Tx_Done,
    input  logic                 i_Rx_Serial,
    output logic                 o_Rx_DV,
    output logic [DATA_BITS-1:0] o_Rx_Byte,
    input  logic                 i_Rx_Rd,
    input  logic                 i_Err_Clr,
    output logic                 o_Rx_Frame_Err,
    output logic                 o_Rx_Parity_Err,
    output logic                 o_Rx_Overrun
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int CLK_W = $clog2(CLKS_PER_BIT);
    localparam logic [CLK_W-1:0] CLK_ZERO  = {CLK_W{1'b0}};
    localparam logic [CLK_W-1:0] CLK_ONE   = CLK_W'(1);
    localparam logic [CLK_W-1:0] CLK_LAST  = CLK_W'(CLKS_PER_BIT - 1);
    localparam logic [CLK_W-1:0] CLK_PRE   = CLK_W'(CLKS_PER_BIT - 2);
    localparam logic [CLK_W-1:0] CLK_HALF  = CLK_W'(CLKS_PER_BIT / 2);
    localparam logic [3:0]       BIT_LAST  = 4'(DATA_BITS - 1);
    localparam logic             STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [DATA_BITS-1:0] WORD_ZERO = {DATA_BITS{1'b0}};

    typedef enum logic [2:0] {
        TX_IDLE  = 3'd0,
        TX_START = 3'd1,
        TX_DATA  = 3'd2,
        TX_PAR   = 3'd3,
        TX_STOP  = 3'd4
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE  = 3'd0,
        RX_START = 3'd1,
        RX_DATA  = 3'd2,
        RX_PAR   = 3'd3,
        RX_STOP  = 3'd4
    } rx_state_t;

    // Parity bit for a payload word: even = XOR of data, odd = its inverse.
    function automatic logic calc_parity(input logic [DATA_BITS-1:0] d);
        return (PARITY == 2) ? ~(^d) : (^d);
    endfunction

    // ---------------- TX FIFO ----------------
    logic [DATA_BITS-1:0] tx_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     tx_wr_ptr_q, tx_rd_ptr_q;
    logic [CNT_W-1:0]     tx_cnt_q, tx_cnt_d;
    logic                 tx_push_s, tx_pop_s, tx_stop_end_s;
    logic [DATA_BITS-1:0] tx_head_s;

    tx_state_t            tx_state_q;
    logic [CLK_W-1:0]     tx_clk_q;
    logic [3:0]           tx_bit_q;
    logic                 tx_stop_q;
    logic [DATA_BITS-1:0] tx_sh_q;
    logic                 tx_par_q;
    logic                 tx_serial_q, tx_active_q, tx_done_q;

    assign tx_push_s = i_Tx_DV && (tx_cnt_q != CNT_FULL);
    assign tx_head_s = tx_mem[tx_rd_ptr_q];

    // TX pop happens exactly when the FSM loads a new word into its shifter.
    always_comb begin
        tx_stop_end_s = (tx_state_q == TX_STOP) && (tx_clk_q == CLK_LAST) && (tx_stop_q == STOP_LAST);
        if (((tx_state_q == TX_IDLE) || tx_stop_end_s) && (tx_cnt_q != CNT_ZERO)) begin
            tx_pop_s = 1'b1;
        end else begin
            tx_pop_s = 1'b0;
        end
    end

    // TX occupancy next-state.
    always_comb begin
        case ({tx_push_s, tx_pop_s})
            2'b10:   tx_cnt_d = tx_cnt_q + CNT_ONE;
            2'b01:   tx_cnt_d = tx_cnt_q - CNT_ONE;
            default: tx_cnt_d = tx_cnt_q;
        endcase
    end

    // TX storage array; contents need no reset because occupancy gates every read.
    always_ff @(posedge i_Clock) begin
        if (tx_push_s) begin
            tx_mem[tx_wr_ptr_q] <= i_Tx_Byte;
        end
    end

    // TX FIFO pointers and count.
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            tx_wr_ptr_q <= {PTR_W{1'b0}};
            tx_rd_ptr_q <= {PTR_W{1'b0}};
            tx_cnt_q    <= CNT_ZERO;
        end else begin
            if (tx_push_s) tx_wr_ptr_q <= tx_wr_ptr_q + PTR_ONE;
            if (tx_pop_s)  tx_rd_ptr_q <= tx_rd_ptr_q + PTR_ONE;
            tx_cnt_q <= tx_cnt_d;
        end
    end

    // TX frame sequencer with registered line, active and done outputs.
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            tx_state_q  <= TX_IDLE;
            tx_clk_q    <= CLK_ZERO;
            tx_bit_q    <= 4'd0;
            tx_stop_q   <= 1'b0;
            tx_sh_q     <= WORD_ZERO;
            tx_par_q    <= 1'b0;
            tx_serial_q <= 1'b1;
            tx_active_q <= 1'b0;
            tx_done_q   <= 1'b0;
        end else begin
            tx_done_q <= 1'b0;
            case (tx_state_q)
                TX_IDLE: begin
                    tx_clk_q <= CLK_ZERO;
                    if (tx_cnt_q != CNT_ZERO) begin
                        tx_state_q  <= TX_START;
                        tx_serial_q <= 1'b0;
                        tx_active_q <= 1'b1;
                        tx_sh_q     <= tx_head_s;
                        tx_par_q    <= calc_parity(tx_head_s);
                    end else begin
                        tx_serial_q <= 1'b1;
                        tx_active_q <= 1'b0;
                    end
                end
                TX_START: begin
                    if (tx_clk_q == CLK_LAST) begin
                        tx_clk_q    <= CLK_ZERO;
                        tx_bit_q    <= 4'd0;
                        tx_state_q  <= TX_DATA;
                        tx_serial_q <= tx_sh_q[0];
                        tx_sh_q     <= {1'b0, tx_sh_q[DATA_BITS-1:1]};
                    end else begin
                        tx_clk_q <= tx_clk_q + CLK_ONE;
                    end
                end
                TX_DATA: begin
                    if (tx_clk_q == CLK_LAST) begin
                        tx_clk_q <= CLK_ZERO;
                        if (tx_bit_q == BIT_LAST) begin
                            tx_stop_q <= 1'b0;
                            if (PARITY != 0) begin
                                tx_state_q  <= TX_PAR;
                                tx_serial_q <= tx_par_q;
                            end else begin
                                tx_state_q  <= TX_STOP;
                                tx_serial_q <= 1'b1;
                            end
                        end else begin
                            tx_bit_q    <= tx_bit_q + 4'd1;
                            tx_serial_q <= tx_sh_q[0];
                            tx_sh_q     <= {1'b0, tx_sh_q[DATA_BITS-1:1]};
                        end
                    end else begin
                        tx_clk_q <= tx_clk_q + CLK_ONE;
                    end
                end
                TX_PAR: begin
                    if (tx_clk_q == CLK_LAST) begin
                        tx_clk_q    <= CLK_ZERO;
                        tx_stop_q   <= 1'b0;
                        tx_state_q  <= TX_STOP;
                        tx_serial_q <= 1'b1;
                    end else begin
                        tx_clk_q <= tx_clk_q + CLK_ONE;
                    end
                end
                TX_STOP: begin
                    if ((tx_clk_q == CLK_PRE) && (tx_stop_q == STOP_LAST)) begin
                        tx_done_q <= 1'b1;
                    end
                    if (tx_clk_q == CLK_LAST) begin
                        tx_clk_q <= CLK_ZERO;
                        if (tx_stop_q != STOP_LAST) begin
                            tx_stop_q <= 1'b1;
                        end else if (tx_cnt_q != CNT_ZERO) begin
                            // Chain straight into the next start bit with no idle gap.
                            tx_state_q  <= TX_START;
                            tx_serial_q <= 1'b0;
                            tx_sh_q     <= tx_head_s;
                            tx_par_q    <= calc_parity(tx_head_s);
                        end else begin
                            tx_state_q  <= TX_IDLE;
                            tx_serial_q <= 1'b1;
                            tx_active_q <= 1'b0;
                        end
                    end else begin
                        tx_clk_q <= tx_clk_q + CLK_ONE;
                    end
                end
                default: begin
                    tx_state_q  <= TX_IDLE;
                    tx_serial_q <= 1'b1;
                    tx_active_q <= 1'b0;
                end
            endcase
        end
    end

    assign o_Tx_Ready  = (tx_cnt_q != CNT_FULL);
    assign o_Tx_Serial = tx_serial_q;
    assign o_Tx_Active = tx_active_q;
    assign o_Tx_Done   = tx_done_q;

    // ---------------- RX ----------------
    logic                 rx_sync1_q, rx_sync2_q;
    rx_state_t            rx_state_q;
    logic [CLK_W-1:0]     rx_clk_q;
    logic [3:0]           rx_bit_q;
    logic [DATA_BITS-1:0] rx_sh_q;
    logic                 rx_par_q;
    logic                 rx_wait_high_q;
    logic                 rx_push_q;
    logic [DATA_BITS-1:0] rx_push_data_q;
    logic                 rx_stop_smp_s, rx_frame_set_s, rx_par_set_s, rx_good_s;

    logic [DATA_BITS-1:0] rx_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     rx_wr_ptr_q, rx_rd_ptr_q;
    logic [CNT_W-1:0]     rx_cnt_q, rx_cnt_d;
    logic                 rx_push_s, rx_pop_s, rx_ovr_set_s;
    logic                 frame_err_q, parity_err_q, overrun_q;

    // Two-flop synchroniser; idles high so reset does not look like a start bit.
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            rx_sync1_q <= 1'b1;
            rx_sync2_q <= 1'b1;
        end else begin
            rx_sync1_q <= i_Rx_Serial;
            rx_sync2_q <= rx_sync1_q;
        end
    end

    // Word outcome at the stop-bit sample.
    always_comb begin
        rx_stop_smp_s  = (rx_state_q == RX_STOP) && (rx_clk_q == CLK_LAST);
        rx_frame_set_s = 1'b0;
        rx_par_set_s   = 1'b0;
        rx_good_s      = 1'b0;
        if (rx_stop_smp_s) begin
            if (!rx_sync2_q) begin
                rx_frame_set_s = 1'b1;
            end else if ((PARITY != 0) && (rx_par_q != calc_parity(rx_sh_q))) begin
                rx_par_set_s = 1'b1;
            end else begin
                rx_good_s = 1'b1;
            end
        end else begin
            rx_good_s = 1'b0;
        end
    end

    // RX frame sequencer; a good word is staged for push one cycle after the stop sample.
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            rx_state_q     <= RX_IDLE;
            rx_clk_q       <= CLK_ZERO;
            rx_bit_q       <= 4'd0;
            rx_sh_q        <= WORD_ZERO;
            rx_par_q       <= 1'b0;
            rx_wait_high_q <= 1'b0;
            rx_push_q      <= 1'b0;
            rx_push_data_q <= WORD_ZERO;
        end else begin
            rx_push_q <= rx_good_s;
            if (rx_good_s) rx_push_data_q <= rx_sh_q;
            case (rx_state_q)
                RX_IDLE: begin
                    rx_clk_q <= CLK_ZERO;
                    if (rx_wait_high_q) begin
                        if (rx_sync2_q) rx_wait_high_q <= 1'b0;
                    end else if (!rx_sync2_q) begin
                        rx_state_q <= RX_START;
                    end
                end
                RX_START: begin
                    if (rx_clk_q == CLK_HALF) begin
                        rx_clk_q <= CLK_ZERO;
                        rx_bit_q <= 4'd0;
                        rx_state_q <= rx_sync2_q ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_clk_q <= rx_clk_q + CLK_ONE;
                    end
                end
                RX_DATA: begin
                    if (rx_clk_q == CLK_LAST) begin
                        rx_clk_q <= CLK_ZERO;
                        rx_sh_q  <= {rx_sync2_q, rx_sh_q[DATA_BITS-1:1]};
                        if (rx_bit_q == BIT_LAST) begin
                            rx_state_q <= (PARITY != 0) ? RX_PAR : RX_STOP;
                        end else begin
                            rx_bit_q <= rx_bit_q + 4'd1;
                        end
                    end else begin
                        rx_clk_q <= rx_clk_q + CLK_ONE;
                    end
                end
                RX_PAR: begin
                    if (rx_clk_q == CLK_LAST) begin
                        rx_clk_q   <= CLK_ZERO;
                        rx_par_q   <= rx_sync2_q;
                        rx_state_q <= RX_STOP;
                    end else begin
                        rx_clk_q <= rx_clk_q + CLK_ONE;
                    end
                end
                RX_STOP: begin
                    if (rx_clk_q == CLK_LAST) begin
                        rx_clk_q   <= CLK_ZERO;
                        rx_state_q <= RX_IDLE;
                        if (!rx_sync2_q) rx_wait_high_q <= 1'b1;
                    end else begin
                        rx_clk_q <= rx_clk_q + CLK_ONE;
                    end
                end
                default: rx_state_q <= RX_IDLE;
            endcase
        end
    end

    assign rx_pop_s     = i_Rx_Rd && (rx_cnt_q != CNT_ZERO);
    assign rx_push_s    = rx_push_q && ((rx_cnt_q != CNT_FULL) || rx_pop_s);
    assign rx_ovr_set_s = rx_push_q && (rx_cnt_q == CNT_FULL) && !rx_pop_s;

    // RX occupancy next-state.
    always_comb begin
        case ({rx_push_s, rx_pop_s})
            2'b10:   rx_cnt_d = rx_cnt_q + CNT_ONE;
            2'b01:   rx_cnt_d = rx_cnt_q - CNT_ONE;
            default: rx_cnt_d = rx_cnt_q;
        endcase
    end

    // RX storage array.
    always_ff @(posedge i_Clock) begin
        if (rx_push_s) begin
            rx_mem[rx_wr_ptr_q] <= rx_push_data_q;
        end
    end

    // RX FIFO pointers and count.
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            rx_wr_ptr_q <= {PTR_W{1'b0}};
            rx_rd_ptr_q <= {PTR_W{1'b0}};
            rx_cnt_q    <= CNT_ZERO;
        end else begin
            if (rx_push_s) rx_wr_ptr_q <= rx_wr_ptr_q + PTR_ONE;
            if (rx_pop_s)  rx_rd_ptr_q <= rx_rd_ptr_q + PTR_ONE;
            rx_cnt_q <= rx_cnt_d;
        end
    end

    // Sticky error flags; a set in the same cycle as a clear takes priority.
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            if (rx_frame_set_s)  frame_err_q <= 1'b1;
            else if (i_Err_Clr)  frame_err_q <= 1'b0;
            else                 frame_err_q <= frame_err_q;
            if (rx_par_set_s)    parity_err_q <= 1'b1;
            else if (i_Err_Clr)  parity_err_q <= 1'b0;
            else                 parity_err_q <= parity_err_q;
            if (rx_ovr_set_s)    overrun_q <= 1'b1;
            else if (i_Err_Clr)  overrun_q <= 1'b0;
            else                 overrun_q <= overrun_q;
        end
    end

    assign o_Rx_DV         = (rx_cnt_q != CNT_ZERO);
    assign o_Rx_Byte       = (rx_cnt_q != CNT_ZERO) ? rx_mem[rx_rd_ptr_q] : WORD_ZERO;
    assign o_Rx_Frame_Err  = frame_err_q;
    assign o_Rx_Parity_Err = parity_err_q;
    assign o_Rx_Overrun    = overrun_q;

endmodule

// File: tb/tb_uart_fifo_transceiver.sv
// Directed bench: u_dut (no parity) runs TX looped to RX or a driven line; u_par (even parity) is driven directly.
module tb_uart_fifo_transceiver;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tx_dv = 1'b0;
    logic [7:0] tx_byte = 8'h00;
    logic       tx_ready, tx_serial, tx_active, tx_done;
    logic       loop_en = 1'b1;
    logic       drv = 1'b1;
    logic       rx_line;
    logic       rx_dv;
    logic [7:0] rx_byte;
    logic       rx_rd = 1'b0;
    logic       err_clr = 1'b0;
    logic       frame_err, parity_err, overrun;

    logic       p_tx_dv = 1'b0;
    logic [7:0] p_tx_byte = 8'h00;
    logic       p_tx_ready, p_tx_serial, p_tx_active, p_tx_done;
    logic       drvp = 1'b1;
    logic       p_rx_dv;
    logic [7:0] p_rx_byte;
    logic       p_rx_rd = 1'b0;
    logic       p_frame_err, p_parity_err, p_overrun;

    int checks = 0;
    int errors = 0;

    assign rx_line = loop_en ? tx_serial : drv;

    always #5 clk = ~clk;

    uart_fifo_transceiver #(
        .CLKS_PER_BIT(8), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)
    ) u_dut (
        .i_Clock(clk), .i_Rst_n(rst_n),
        .i_Tx_DV(tx_dv), .i_Tx_Byte(tx_byte), .o_Tx_Ready(tx_ready),
        .o_Tx_Serial(tx_serial), .o_Tx_Active(tx_active), .o_Tx_Done(tx_done),
        .i_Rx_Serial(rx_line), .o_Rx_DV(rx_dv), .o_Rx_Byte(rx_byte), .i_Rx_Rd(rx_rd),
        .i_Err_Clr(err_clr), .o_Rx_Frame_Err(frame_err), .o_Rx_Parity_Err(parity_err),
        .o_Rx_Overrun(overrun)
    );

    uart_fifo_transceiver #(
        .CLKS_PER_BIT(8), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)
    ) u_par (
        .i_Clock(clk), .i_Rst_n(rst_n),
        .i_Tx_DV(p_tx_dv), .i_Tx_Byte(p_tx_byte), .o_Tx_Ready(p_tx_ready),
        .o_Tx_Serial(p_tx_serial), .o_Tx_Active(p_tx_active), .o_Tx_Done(p_tx_done),
        .i_Rx_Serial(drvp), .o_Rx_DV(p_rx_dv), .o_Rx_Byte(p_rx_byte), .i_Rx_Rd(p_rx_rd),
        .i_Err_Clr(err_clr), .o_Rx_Frame_Err(p_frame_err), .o_Rx_Parity_Err(p_parity_err),
        .o_Rx_Overrun(p_overrun)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_line(input bit sel, input logic v);
        if (sel) drvp = v;
        else     drv  = v;
    endtask

    // Drives start, 8 data bits LSB first, optional parity and one stop bit; line left at stop level.
    task automatic send_frame(input bit sel, input logic [7:0] d, input bit has_par,
                              input logic par, input logic stopb);
        set_line(sel, 1'b0);
        repeat (8) tick();
        for (int i = 0; i < 8; i++) begin
            set_line(sel, d[i]);
            repeat (8) tick();
        end
        if (has_par) begin
            set_line(sel, par);
            repeat (8) tick();
        end
        set_line(sel, stopb);
        repeat (8) tick();
    endtask

    task automatic wait_rx_dv(input int budget);
        for (int k = 0; k < budget && !rx_dv; k++) tick();
    endtask

    task automatic pop_rx();
        rx_rd = 1'b1;
        tick();
        rx_rd = 1'b0;
    endtask

    logic [9:0] t1_bits = 10'b1101001010;
    logic [7:0] t2_w [0:4] = '{8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    logic [7:0] t5_w [0:4] = '{8'hC3, 8'h3C, 8'h96, 8'h69, 8'hF0};
    logic [7:0] rx_got [0:7];
    int dones, act_cnt, last_act, rx_n;

    initial begin
        // Reset state
        repeat (3) tick();
        chk("rst_tx_serial", {31'd0, tx_serial}, 32'd1);
        chk("rst_tx_ready",  {31'd0, tx_ready},  32'd1);
        chk("rst_tx_active", {31'd0, tx_active}, 32'd0);
        chk("rst_tx_done",   {31'd0, tx_done},   32'd0);
        chk("rst_rx_dv",     {31'd0, rx_dv},     32'd0);
        chk("rst_rx_byte",   {24'd0, rx_byte},   32'd0);
        chk("rst_errs",      {29'd0, frame_err, parity_err, overrun}, 32'd0);
        rst_n = 1'b1;
        repeat (3) tick();

        // 1: single 0xA5 frame looped back
        tx_byte = 8'hA5; tx_dv = 1'b1;
        tick();
        tx_dv = 1'b0;
        tick();
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            for (int c = 0; c < 8; c++) begin
                if (c == 3) chk($sformatf("t1_bit%0d", i), {31'd0, tx_serial}, {31'd0, t1_bits[i]});
                if (tx_done) dones++;
                tick();
            end
        end
        chk("t1_done_once", dones, 32'd1);
        chk("t1_active_end", {31'd0, tx_active}, 32'd0);
        wait_rx_dv(20);
        chk("t1_rx_dv", {31'd0, rx_dv}, 32'd1);
        chk("t1_rx_byte", {24'd0, rx_byte}, 32'h000000A5);
        pop_rx();
        chk("t1_rx_dv_pop", {31'd0, rx_dv}, 32'd0);
        chk("t1_rx_byte_pop", {24'd0, rx_byte}, 32'd0);
        repeat (10) tick();

        // 2: fill TX FIFO behind a frame in flight, 5th push dropped, back-to-back frames
        tx_byte = 8'h11; tx_dv = 1'b1;
        tick();
        tx_dv = 1'b0;
        act_cnt = 0; last_act = -1; dones = 0; rx_n = 0;
        for (int c = 0; c < 460; c++) begin
            if (tx_active) begin act_cnt++; last_act = c; end
            if (tx_done) dones++;
            if (c == 5) chk("t2_ready_full", {31'd0, tx_ready}, 32'd0);
            if (rx_dv) begin
                if (rx_n < 8) rx_got[rx_n] = rx_byte;
                rx_n++;
                rx_rd = 1'b1;
            end else begin
                rx_rd = 1'b0;
            end
            if (c >= 1 && c <= 5) begin
                tx_dv = 1'b1;
                tx_byte = t2_w[c-1];
            end else begin
                tx_dv = 1'b0;
            end
            tick();
        end
        rx_rd = 1'b0;
        chk("t2_active_cycles", act_cnt, 32'd400);
        chk("t2_last_active", last_act, 32'd400);
        chk("t2_done_count", dones, 32'd5);
        chk("t2_rx_count", rx_n, 32'd5);
        chk("t2_rx0", {24'd0, rx_got[0]}, 32'h11);
        for (int k = 1; k < 5; k++) chk($sformatf("t2_rx%0d", k), {24'd0, rx_got[k]}, {24'd0, t2_w[k-1]});

        // 3: parity errors on the even-parity instance
        send_frame(1'b1, 8'h07, 1'b1, 1'b0, 1'b1);
        repeat (20) tick();
        chk("t3_par_err_set", {31'd0, p_parity_err}, 32'd1);
        chk("t3_bad_not_stored", {31'd0, p_rx_dv}, 32'd0);
        chk("t3_no_frame_err", {31'd0, p_frame_err}, 32'd0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("t3_par_err_clr", {31'd0, p_parity_err}, 32'd0);
        send_frame(1'b1, 8'h07, 1'b1, 1'b1, 1'b1);
        repeat (20) tick();
        chk("t3_good_dv", {31'd0, p_rx_dv}, 32'd1);
        chk("t3_good_byte", {24'd0, p_rx_byte}, 32'h07);
        chk("t3_good_no_err", {31'd0, p_parity_err}, 32'd0);
        p_rx_rd = 1'b1;
        tick();
        p_rx_rd = 1'b0;

        // 4: framing error, line held low, recovery only after line high
        drv = 1'b1;
        loop_en = 1'b0;
        repeat (4) tick();
        send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0);
        repeat (40) tick();
        chk("t4_frame_err", {31'd0, frame_err}, 32'd1);
        chk("t4_fifo_empty", {31'd0, rx_dv}, 32'd0);
        drv = 1'b1;
        repeat (20) tick();
        send_frame(1'b0, 8'h5A, 1'b0, 1'b0, 1'b1);
        repeat (20) tick();
        chk("t4_recover_dv", {31'd0, rx_dv}, 32'd1);
        chk("t4_recover_byte", {24'd0, rx_byte}, 32'h5A);
        chk("t4_frame_sticky", {31'd0, frame_err}, 32'd1);
        pop_rx();

        // 5: overrun with 5 frames into a depth-4 RX FIFO
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("t5_clr_frame", {31'd0, frame_err}, 32'd0);
        loop_en = 1'b1;
        repeat (4) tick();
        for (int k = 0; k < 5; k++) begin
            tx_dv = 1'b1;
            tx_byte = t5_w[k];
            tick();
        end
        tx_dv = 1'b0;
        repeat (440) tick();
        chk("t5_overrun", {31'd0, overrun}, 32'd1);
        chk("t5_no_frame_err", {31'd0, frame_err}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("t5_dv%0d", k), {31'd0, rx_dv}, 32'd1);
            chk($sformatf("t5_word%0d", k), {24'd0, rx_byte}, {24'd0, t5_w[k]});
            pop_rx();
        end
        chk("t5_empty", {31'd0, rx_dv}, 32'd0);

        // 5b: three-clock glitch is rejected silently
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        drv = 1'b1;
        loop_en = 1'b0;
        repeat (4) tick();
        drv = 1'b0;
        repeat (3) tick();
        drv = 1'b1;
        repeat (30) tick();
        chk("t5_glitch_dv", {31'd0, rx_dv}, 32'd0);
        chk("t5_glitch_errs", {29'd0, frame_err, parity_err, overrun}, 32'd0);

        // 6: asynchronous reset in the middle of a TX data bit
        loop_en = 1'b1;
        repeat (4) tick();
        tx_byte = 8'h3C; tx_dv = 1'b1;
        tick();
        tx_dv = 1'b0;
        wait_rx_dv(200);
        chk("t6_rx_word", {31'd0, rx_dv}, 32'd1);
        tx_byte = 8'hA5; tx_dv = 1'b1;
        tick();
        tx_byte = 8'h77;
        tick();
        tx_dv = 1'b0;
        repeat (19) tick();
        chk("t6_mid_bit1", {31'd0, tx_serial}, 32'd0);
        chk("t6_mid_active", {31'd0, tx_active}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_serial", {31'd0, tx_serial}, 32'd1);
        chk("t6_rst_active", {31'd0, tx_active}, 32'd0);
        chk("t6_rst_rx_dv", {31'd0, rx_dv}, 32'd0);
        chk("t6_rst_ready", {31'd0, tx_ready}, 32'd1);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (10) tick();
        chk("t6_post_serial", {31'd0, tx_serial}, 32'd1);
        chk("t6_post_active", {31'd0, tx_active}, 32'd0);
        chk("t6_post_rx_dv", {31'd0, rx_dv}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
